// File: rtl/nms_window_stream.sv
// Streaming non-maximum suppression over an NMS_SIZE x NMS_SIZE window of corner
// flags/scores; one result per interior pixel, registered two cycles after acceptance.
module nms_window_stream #(
  parameter int COL_NUM  = 640,
  parameter int ROW_NUM  = 480,
  parameter int NMS_SIZE = 3,
  parameter int SCORE_W  = 13,
  parameter int COORD_W  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic                 sof,
  input  logic                 iscorner_in,
  input  logic [SCORE_W-1:0]   score_in,
  output logic                 out_vld,
  output logic [COORD_W-1:0]   x_coord_out,
  output logic [COORD_W-1:0]   y_coord_out,
  output logic                 corner_out,
  output logic [SCORE_W-1:0]   score_out,
  output logic                 frame_done,
  output logic [2*COORD_W-1:0] kept_cnt,
  output logic                 sof_err
);
  localparam int N      = NMS_SIZE;
  localparam int R      = (NMS_SIZE-1)/2;
  localparam int STAGES = 2;
  localparam int AW     = $clog2(COL_NUM);
  localparam int PW     = SCORE_W+1;
  localparam int CW     = 2*COORD_W;
  localparam logic [0:0] WAIT_SOF = 1'b0;
  localparam logic [0:0] RUN      = 1'b1;

  logic [0:0]         state;
  logic [COORD_W-1:0] x_cnt, y_cnt, cur_x, cur_y;
  logic               start, accept, err_now, is_last, emit;
  logic [AW-1:0]      rd_a;

  // A sof pixel is always (0,0), whether it opens a frame or restarts one.
  always_comb begin
    start   = in_vld & sof;
    accept  = in_vld & ((state == RUN) | sof);
    err_now = start & (state == RUN);
    cur_x   = start ? '0 : x_cnt;
    cur_y   = start ? '0 : y_cnt;
    is_last = (cur_x == COORD_W'(COL_NUM-1)) && (cur_y == COORD_W'(ROW_NUM-1));
    emit    = accept && (cur_x >= COORD_W'(2*R)) && (cur_y >= COORD_W'(2*R));
    rd_a    = cur_x[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= WAIT_SOF;
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      if (is_last) begin
        state <= WAIT_SOF;
        x_cnt <= '0;
        y_cnt <= '0;
      end else begin
        state <= RUN;
        if (cur_x == COORD_W'(COL_NUM-1)) begin
          x_cnt <= '0;
          y_cnt <= cur_y + COORD_W'(1);
        end else begin
          x_cnt <= cur_x + COORD_W'(1);
          y_cnt <= cur_y;
        end
      end
    end
  end

  // lb[0] holds row y-1, lb[N-2] the oldest row; win[r][c], r=0 oldest row, c=0 oldest column.
  logic [PW-1:0]               lb [N-1][COL_NUM];
  logic [N-1:0][PW-1:0]        col;
  logic [N-1:0][N-1:0][PW-1:0] win;

  always_comb begin
    for (int r = 0; r < N-1; r++) col[r] = lb[N-2-r][rd_a];
    col[N-1] = {iscorner_in, score_in};
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][rd_a] <= {iscorner_in, score_in};
      for (int k = 1; k < N-1; k++) lb[k][rd_a] <= lb[k-1][rd_a];
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N-1; c++) win[r][c] <= win[r][c+1];
        win[r][N-1] <= col[r];
      end
    end
  end

  // Ties go to the raster-first corner: strict win over earlier, >= over later.
  logic               keep;
  logic [SCORE_W-1:0] cs;
  always_comb begin
    cs   = win[R][R][SCORE_W-1:0];
    keep = win[R][R][SCORE_W];
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (!(r == R && c == R) && win[r][c][SCORE_W]) begin
          if ((r < R || (r == R && c < R)) ? (cs <= win[r][c][SCORE_W-1:0])
                                           : (cs <  win[r][c][SCORE_W-1:0]))
            keep = 1'b0;
        end
  end

  logic [STAGES:0]    vld_pipe, err_pipe, last_pipe;
  logic [COORD_W-1:0] s1_x, s1_y, s2_x, s2_y;
  logic               s2_corner;
  logic [SCORE_W-1:0] s2_score;
  logic [CW-1:0]      run_cnt, run_nxt;
  logic               hit;

  always_ff @(posedge clk) begin
    if (emit) begin
      s1_x <= cur_x - COORD_W'(R);
      s1_y <= cur_y - COORD_W'(R);
    end
    if (vld_pipe[0]) begin
      s2_x      <= s1_x;
      s2_y      <= s1_y;
      s2_corner <= keep;
      s2_score  <= cs;
    end
  end

  always_comb begin
    hit     = vld_pipe[STAGES-1] & s2_corner;
    run_nxt = (hit && run_cnt != '1) ? run_cnt + CW'(1) : run_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe    <= '0;
      err_pipe    <= '0;
      last_pipe   <= '0;
      x_coord_out <= '0;
      y_coord_out <= '0;
      corner_out  <= 1'b0;
      score_out   <= '0;
      kept_cnt    <= '0;
      run_cnt     <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], emit};
      err_pipe  <= {err_pipe[STAGES-1:0], err_now};
      last_pipe <= {last_pipe[STAGES-1:0], accept & is_last};
      if (vld_pipe[STAGES-1]) begin
        x_coord_out <= s2_x;
        y_coord_out <= s2_y;
        corner_out  <= s2_corner;
        score_out   <= s2_score;
      end
      if (err_pipe[STAGES-1]) begin
        run_cnt <= '0;
      end else if (last_pipe[STAGES-1]) begin
        kept_cnt <= run_nxt;
        run_cnt  <= '0;
      end else begin
        run_cnt <= run_nxt;
      end
    end
  end

  assign out_vld    = vld_pipe[STAGES];
  assign sof_err    = err_pipe[STAGES];
  assign frame_done = last_pipe[STAGES];
endmodule

// File: tb/tb_nms_window_stream.sv
// Bench for nms_window_stream: 8x6 frames driven into a 3x3 and a 5x5 instance,
// results compared against a coordinate-level NMS model.
module tb_nms_window_stream;
  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int INF  = 1 << 30;

  typedef struct packed {
    int   cyc;
    logic vld;
    logic fd;
    logic err;
    logic cor;
    int   x;
    int   y;
    int   sc;
    int   kept;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, in_vld, sof, iscorner_in;
  logic [12:0] score_in;
  logic        out_vld3, corner3, frame_done3, sof_err3;
  logic        out_vld5, corner5, frame_done5, sof_err5;
  logic [9:0]  x3, y3, x5, y5;
  logic [12:0] score3, score5;
  logic [19:0] kept3, kept5;

  nms_window_stream #(.COL_NUM(COLS), .ROW_NUM(ROWS), .NMS_SIZE(3), .SCORE_W(13), .COORD_W(10)) dut3 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .sof(sof), .iscorner_in(iscorner_in), .score_in(score_in),
    .out_vld(out_vld3), .x_coord_out(x3), .y_coord_out(y3), .corner_out(corner3), .score_out(score3),
    .frame_done(frame_done3), .kept_cnt(kept3), .sof_err(sof_err3));

  nms_window_stream #(.COL_NUM(COLS), .ROW_NUM(ROWS), .NMS_SIZE(5), .SCORE_W(13), .COORD_W(10)) dut5 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .sof(sof), .iscorner_in(iscorner_in), .score_in(score_in),
    .out_vld(out_vld5), .x_coord_out(x5), .y_coord_out(y5), .corner_out(corner5), .score_out(score5),
    .frame_done(frame_done5), .kept_cnt(kept5), .sof_err(sof_err5));

  always #5 clk = ~clk;

  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;
  int   ek3, ek5;
  int   fc [3][ROWS][COLS];
  int   fs [3][ROWS][COLS];
  int   acyc [3][ROWS][COLS];
  obs_t oq3[$], oq5[$], eq3[$], eq5[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are sampled on the falling edge; data fields are only meaningful with their strobe.
  always @(negedge clk) begin
    obs_t o;
    if (out_vld3 || frame_done3 || sof_err3) begin
      o = '0;
      o.cyc = cyc; o.vld = out_vld3; o.fd = frame_done3; o.err = sof_err3;
      if (out_vld3) begin o.cor = corner3; o.x = int'(x3); o.y = int'(y3); o.sc = int'(score3); end
      if (frame_done3) o.kept = int'(kept3);
      oq3.push_back(o);
    end
    if (out_vld5 || frame_done5 || sof_err5) begin
      o = '0;
      o.cyc = cyc; o.vld = out_vld5; o.fd = frame_done5; o.err = sof_err5;
      if (out_vld5) begin o.cor = corner5; o.x = int'(x5); o.y = int'(y5); o.sc = int'(score5); end
      if (frame_done5) o.kept = int'(kept5);
      oq5.push_back(o);
    end
  end

  task automatic pix(input bit v, input bit s, input bit c, input int sc, output int ac);
    @(negedge clk);
    in_vld = v; sof = s; iscorner_in = c; score_in = sc[12:0];
    ac = cyc + 1;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    int a;
    repeat (n) pix(0, 0, 0, 0, a);
  endtask

  // gap: 0 none, 1 one idle cycle between pixels, 2 random idles
  task automatic send(input int f, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int x, y, a;
      x = i % COLS; y = i / COLS;
      if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(3) == 0)) pix(0, 0, 0, 0, a);
      pix(1, i == 0, fc[f][y][x] != 0, fs[f][y][x], a);
      acyc[f][y][x] = a;
    end
  endtask

  task automatic clr(input int f);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin fc[f][y][x] = 0; fs[f][y][x] = 0; end
  endtask

  task automatic clear_q();
    oq3.delete(); oq5.delete(); eq3.delete(); eq5.delete();
  endtask

  // Reference: the first n raster pixels of frame f; results landing at or after lim are dropped.
  task automatic exp_frame(input int f, input int n, input int r, input int lim);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      int x, y, cx, cy, cs, ns;
      bit cor;
      obs_t e;
      x = i % COLS; y = i / COLS;
      if (x >= 2*r && y >= 2*r) begin
        cx = x - r; cy = y - r;
        cor = fc[f][cy][cx] != 0; cs = fs[f][cy][cx];
        for (int dy = -r; dy <= r; dy++)
          for (int dx = -r; dx <= r; dx++)
            if ((dy != 0 || dx != 0) && fc[f][cy+dy][cx+dx] != 0) begin
              ns = fs[f][cy+dy][cx+dx];
              if ((dy < 0 || (dy == 0 && dx < 0)) ? (cs <= ns) : (cs < ns)) cor = 0;
            end
        if (cor) cnt++;
        e = '0;
        e.cyc = acyc[f][y][x] + 2; e.vld = 1'b1; e.fd = (i == COLS*ROWS-1);
        e.cor = cor; e.x = cx; e.y = cy; e.sc = cs;
        if (e.fd) begin
          e.kept = cnt;
          if (r == 1) ek3 = cnt; else ek5 = cnt;
        end
        if (e.cyc < lim) begin
          if (r == 1) eq3.push_back(e); else eq5.push_back(e);
        end
      end
    end
  endtask

  task automatic exp_err(input int c);
    obs_t e;
    e = '0; e.cyc = c; e.err = 1'b1;
    eq3.push_back(e); eq5.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b0; in_vld = 1'b1; sof = 1'b1; iscorner_in = 1'b1; score_in = 13'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nchk++;
    if ({out_vld3, x3, y3, corner3, score3, frame_done3, kept3, sof_err3} !== '0) begin
      nfail++; $display("FAIL reset dut3: outputs %0h, expected 0",
        {out_vld3, x3, y3, corner3, score3, frame_done3, kept3, sof_err3});
    end
    nchk++;
    if ({out_vld5, x5, y5, corner5, score5, frame_done5, kept5, sof_err5} !== '0) begin
      nfail++; $display("FAIL reset dut5: outputs %0h, expected 0",
        {out_vld5, x5, y5, corner5, score5, frame_done5, kept5, sof_err5});
    end
    rst = 1'b1; in_vld = 1'b0; sof = 1'b0;
  endtask

  task automatic test_all_zero();
    clear_q(); clr(0);
    send(0, 48, 0); idle(6);
    exp_frame(0, 48, 1, INF); exp_frame(0, 48, 2, INF);
    for (int k = 0; k < 2; k++) begin
      int no, ne;
      no = k ? oq5.size() : oq3.size(); ne = k ? eq5.size() : eq3.size();
      nchk++;
      if (no !== ne) begin nfail++; $display("FAIL all_zero count dut%0d: %0d events, expected %0d", k, no, ne); end
      for (int i = 0; i < no && i < ne; i++) begin
        obs_t o, e;
        o = k ? oq5[i] : oq3[i]; e = k ? eq5[i] : eq3[i];
        nchk++;
        if (o !== e) begin nfail++; $display("FAIL all_zero event dut%0d #%0d: got %p, expected %p", k, i, o, e); end
      end
    end
    nchk++;
    if (kept3 !== 20'(ek3) || kept5 !== 20'(ek5)) begin
      nfail++; $display("FAIL all_zero kept_cnt: got %0d/%0d, expected %0d/%0d", kept3, kept5, ek3, ek5);
    end
  endtask

  task automatic test_single(input int gap);
    clear_q(); clr(0);
    fc[0][2][3] = 1; fs[0][2][3] = 100;
    send(0, 48, gap); idle(6);
    exp_frame(0, 48, 1, INF); exp_frame(0, 48, 2, INF);
    for (int k = 0; k < 2; k++) begin
      int no, ne;
      no = k ? oq5.size() : oq3.size(); ne = k ? eq5.size() : eq3.size();
      nchk++;
      if (no !== ne) begin nfail++; $display("FAIL single gap%0d count dut%0d: %0d events, expected %0d", gap, k, no, ne); end
      for (int i = 0; i < no && i < ne; i++) begin
        obs_t o, e;
        o = k ? oq5[i] : oq3[i]; e = k ? eq5[i] : eq3[i];
        nchk++;
        if (o !== e) begin nfail++; $display("FAIL single gap%0d event dut%0d #%0d: got %p, expected %p", gap, k, i, o, e); end
      end
    end
    nchk++;
    if (kept3 !== 20'(ek3) || kept5 !== 20'(ek5)) begin
      nfail++; $display("FAIL single gap%0d kept_cnt: got %0d/%0d, expected %0d/%0d", gap, kept3, kept5, ek3, ek5);
    end
  endtask

  // Two frames back to back: equal-score pair, then the later corner one higher.
  task automatic test_tie();
    clear_q(); clr(0); clr(1);
    fc[0][2][3] = 1; fs[0][2][3] = 50; fc[0][2][4] = 1; fs[0][2][4] = 50;
    fc[1][2][3] = 1; fs[1][2][3] = 50; fc[1][2][4] = 1; fs[1][2][4] = 51;
    send(0, 48, 0); send(1, 48, 0); idle(6);
    exp_frame(0, 48, 1, INF); exp_frame(1, 48, 1, INF);
    exp_frame(0, 48, 2, INF); exp_frame(1, 48, 2, INF);
    for (int k = 0; k < 2; k++) begin
      int no, ne;
      no = k ? oq5.size() : oq3.size(); ne = k ? eq5.size() : eq3.size();
      nchk++;
      if (no !== ne) begin nfail++; $display("FAIL tie count dut%0d: %0d events, expected %0d", k, no, ne); end
      for (int i = 0; i < no && i < ne; i++) begin
        obs_t o, e;
        o = k ? oq5[i] : oq3[i]; e = k ? eq5[i] : eq3[i];
        nchk++;
        if (o !== e) begin nfail++; $display("FAIL tie event dut%0d #%0d: got %p, expected %p", k, i, o, e); end
      end
    end
  endtask

  // sof at (5,3) restarts the frame; the aborted frame's kept corner must not count.
  task automatic test_sof_err();
    clear_q(); clr(0); clr(1);
    fc[0][2][3] = 1; fs[0][2][3] = 100;
    fc[1][2][3] = 1; fs[1][2][3] = 7;
    send(0, 29, 0); send(1, 48, 0); idle(6);
    exp_frame(0, 29, 1, INF); exp_frame(0, 29, 2, INF);
    exp_err(acyc[1][0][0] + 2);
    exp_frame(1, 48, 1, INF); exp_frame(1, 48, 2, INF);
    for (int k = 0; k < 2; k++) begin
      int no, ne;
      no = k ? oq5.size() : oq3.size(); ne = k ? eq5.size() : eq3.size();
      nchk++;
      if (no !== ne) begin nfail++; $display("FAIL sof_err count dut%0d: %0d events, expected %0d", k, no, ne); end
      for (int i = 0; i < no && i < ne; i++) begin
        obs_t o, e;
        o = k ? oq5[i] : oq3[i]; e = k ? eq5[i] : eq3[i];
        nchk++;
        if (o !== e) begin nfail++; $display("FAIL sof_err event dut%0d #%0d: got %p, expected %p", k, i, o, e); end
      end
    end
    nchk++;
    if (kept3 !== 20'(ek3) || kept5 !== 20'(ek5)) begin
      nfail++; $display("FAIL sof_err kept_cnt: got %0d/%0d, expected %0d/%0d", kept3, kept5, ek3, ek5);
    end
  endtask

  task automatic test_mid_reset();
    int rcyc, a;
    clear_q(); clr(0); clr(1);
    fc[0][2][2] = 1; fs[0][2][2] = 9;
    fc[1][3][5] = 1; fs[1][3][5] = 3;
    send(0, 30, 0);
    @(negedge clk);
    rst = 1'b0; in_vld = 1'b0; rcyc = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    nchk++;
    if ({out_vld3, x3, y3, corner3, score3, frame_done3, kept3, sof_err3,
         out_vld5, x5, y5, corner5, score5, frame_done5, kept5, sof_err5} !== '0) begin
      nfail++; $display("FAIL mid_reset outputs: got %0h/%0h, expected 0",
        {out_vld3, x3, y3, corner3, score3, frame_done3, kept3, sof_err3},
        {out_vld5, x5, y5, corner5, score5, frame_done5, kept5, sof_err5});
    end
    rst = 1'b1;
    repeat (5) pix(1, 0, 1, 99, a);
    idle(2);
    send(1, 48, 0); idle(6);
    exp_frame(0, 30, 1, rcyc); exp_frame(0, 30, 2, rcyc);
    exp_frame(1, 48, 1, INF); exp_frame(1, 48, 2, INF);
    for (int k = 0; k < 2; k++) begin
      int no, ne;
      no = k ? oq5.size() : oq3.size(); ne = k ? eq5.size() : eq3.size();
      nchk++;
      if (no !== ne) begin nfail++; $display("FAIL mid_reset count dut%0d: %0d events, expected %0d", k, no, ne); end
      for (int i = 0; i < no && i < ne; i++) begin
        obs_t o, e;
        o = k ? oq5[i] : oq3[i]; e = k ? eq5[i] : eq3[i];
        nchk++;
        if (o !== e) begin nfail++; $display("FAIL mid_reset event dut%0d #%0d: got %p, expected %p", k, i, o, e); end
      end
    end
    nchk++;
    if (kept3 !== 20'(ek3) || kept5 !== 20'(ek5)) begin
      nfail++; $display("FAIL mid_reset kept_cnt: got %0d/%0d, expected %0d/%0d", kept3, kept5, ek3, ek5);
    end
  endtask

  // (6,5) lies on the border: it suppresses (4,3) in the 5x5 window but is never emitted.
  task automatic test_nms5();
    clear_q(); clr(0);
    fc[0][3][4] = 1; fs[0][3][4] = 10; fc[0][5][6] = 1; fs[0][5][6] = 20;
    send(0, 48, 0); idle(6);
    exp_frame(0, 48, 1, INF); exp_frame(0, 48, 2, INF);
    for (int k = 0; k < 2; k++) begin
      int no, ne;
      no = k ? oq5.size() : oq3.size(); ne = k ? eq5.size() : eq3.size();
      nchk++;
      if (no !== ne) begin nfail++; $display("FAIL nms5 count dut%0d: %0d events, expected %0d", k, no, ne); end
      for (int i = 0; i < no && i < ne; i++) begin
        obs_t o, e;
        o = k ? oq5[i] : oq3[i]; e = k ? eq5[i] : eq3[i];
        nchk++;
        if (o !== e) begin nfail++; $display("FAIL nms5 event dut%0d #%0d: got %p, expected %p", k, i, o, e); end
      end
    end
    nchk++;
    if (kept5 !== 20'd0 || kept3 !== 20'(ek3)) begin
      nfail++; $display("FAIL nms5 kept_cnt: got %0d/%0d, expected %0d/0", kept3, kept5, ek3);
    end
  endtask

  // Random corners with heavy score ties and full-width scores, random gaps, frames back to back.
  task automatic test_random();
    clear_q();
    for (int f = 0; f < 3; f++)
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++) begin
          fc[f][y][x] = ($urandom_range(2) == 0) ? 1 : 0;
          fs[f][y][x] = ($urandom_range(1) == 0) ? int'($urandom_range(3)) : 8188 + int'($urandom_range(3));
        end
    for (int f = 0; f < 3; f++) send(f, 48, 2);
    idle(6);
    for (int f = 0; f < 3; f++) begin exp_frame(f, 48, 1, INF); exp_frame(f, 48, 2, INF); end
    for (int k = 0; k < 2; k++) begin
      int no, ne;
      no = k ? oq5.size() : oq3.size(); ne = k ? eq5.size() : eq3.size();
      nchk++;
      if (no !== ne) begin nfail++; $display("FAIL random count dut%0d: %0d events, expected %0d", k, no, ne); end
      for (int i = 0; i < no && i < ne; i++) begin
        obs_t o, e;
        o = k ? oq5[i] : oq3[i]; e = k ? eq5[i] : eq3[i];
        nchk++;
        if (o !== e) begin nfail++; $display("FAIL random event dut%0d #%0d: got %p, expected %p", k, i, o, e); end
      end
    end
    nchk++;
    if (kept3 !== 20'(ek3) || kept5 !== 20'(ek5)) begin
      nfail++; $display("FAIL random kept_cnt: got %0d/%0d, expected %0d/%0d", kept3, kept5, ek3, ek5);
    end
  endtask

  initial begin
    rst = 1'b0; in_vld = 1'b0; sof = 1'b0; iscorner_in = 1'b0; score_in = '0;
    test_reset();
    idle(2);
    test_all_zero();
    test_single(0);
    test_tie();
    test_single(1);
    test_sof_err();
    test_mid_reset();
    test_nms5();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
